// File: rtl/lfsr_prbs.sv
// rtl/lfsr_prbs.sv - Fibonacci PRBS generator plus self-synchronising checker with lock FSM
// Optional error injection on gen_out is compiled in with LFSR_PRBS_ERR_INJ_EN.
module lfsr_prbs #(
    parameter int          WIDTH      = 16,
    parameter logic [31:0] TAPS       = 32'h0000_D008,
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter int          LOCK_CNT   = 8,
    parameter int          UNLOCK_CNT = 4,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             err_inj,
    output logic             gen_out,
    output logic [WIDTH-1:0] gen_state,
    input  logic             chk_en,
    input  logic             chk_in,
    input  logic             err_clr,
    output logic             chk_locked,
    output logic             chk_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] TAP_MASK    = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_INIT   = (SEED[WIDTH-1:0] == '0) ? ONE : SEED[WIDTH-1:0];
    localparam logic [5:0]       FILL_LAST   = 6'(WIDTH - 1);
    localparam logic [15:0]      LOCK_LAST   = 16'(LOCK_CNT - 1);
    localparam logic [15:0]      UNLOCK_LAST = 16'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_t;

    logic fb;
    logic inj;

    assign fb = ^(gen_state & TAP_MASK);

`ifdef LFSR_PRBS_ERR_INJ_EN
    assign inj = err_inj;
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
    assign inj = 1'b0;
`endif

    // Injection corrupts only the emitted bit; the state keeps the true feedback.
    always_ff @(posedge clk) begin
        if (reset) begin
            gen_state <= SEED_INIT;
            gen_out   <= 1'b0;
        end else if (seed_load) begin
            gen_state <= (seed == '0) ? ONE : seed;
        end else if (gen_en) begin
            gen_state <= {gen_state[WIDTH-2:0], fb};
            gen_out   <= fb ^ inj;
        end
    end

    logic [WIDTH-1:0] chk_r;
    logic             pred;
    logic             match;
    chk_state_t       state, state_nxt;
    logic [5:0]       fill, fill_nxt;
    logic [15:0]      hits, hits_nxt;
    logic [15:0]      miss, miss_nxt;
    logic             err_hit;

    assign pred       = ^(chk_r & TAP_MASK);
    assign match      = (chk_in == pred) && (chk_r != '0);
    assign chk_locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        hits_nxt  = hits;
        miss_nxt  = miss;
        err_hit   = 1'b0;
        if (chk_en) begin
            case (state)
                HUNT: begin
                    if (fill == FILL_LAST) begin
                        state_nxt = SYNC;
                        fill_nxt  = '0;
                        hits_nxt  = '0;
                    end else begin
                        fill_nxt = fill + 6'd1;
                    end
                end
                SYNC: begin
                    if (match) begin
                        hits_nxt = hits + 16'd1;
                        if (hits == LOCK_LAST) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end else begin
                        hits_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_nxt = '0;
                    end else begin
                        err_hit = 1'b1;
                        if (miss == UNLOCK_LAST) begin
                            state_nxt = HUNT;
                            fill_nxt  = '0;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss + 16'd1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
            chk_r <= '0;
            fill  <= '0;
            hits  <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
            hits  <= hits_nxt;
            miss  <= miss_nxt;
            if (chk_en) begin
                chk_r <= {chk_r[WIDTH-2:0], chk_in};
            end
        end
    end

    // A clear that lands on a counted error leaves that error in the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_err   <= 1'b0;
            err_count <= '0;
        end else begin
            chk_err <= err_hit;
            if (err_clr) begin
                err_count <= err_hit ? CNT_W'(1) : '0;
            end else if (err_hit && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
